uart_tx_fifo_ctrl: RTL
======================

UART_TX_FIFO_CTRL -- requirements
Module: uart_tx_fifo_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, data byte width for requester, FIFO and transmitter paths.
REQ-002 Parameter CNT_W, default 16, width of the sent-frame counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req0  input  1  requester 0 write request; held until granted.
REQ-006 data0  input  WIDTH  requester 0 write byte.
REQ-007 gnt0  output  1  requester 0 grant; combinational, same cycle as the FIFO write.
REQ-008 req1  input  1  requester 1 write request; held until granted.
REQ-009 data1  input  WIDTH  requester 1 write byte.
REQ-010 gnt1  output  1  requester 1 grant; combinational.
REQ-011 fifo_wr_en  output  1  FIFO write strobe.
REQ-012 fifo_w_data  output  WIDTH  FIFO write byte.
REQ-013 fifo_full  input  1  FIFO full flag.
REQ-014 fifo_rd_en  output  1  FIFO pop strobe, registered.
REQ-015 fifo_r_data  input  WIDTH  FIFO read byte, valid the cycle after the pop edge.
REQ-016 fifo_empty  input  1  FIFO empty flag.
REQ-017 tx_start  output  1  one-cycle, registered transmitter launch pulse.
REQ-018 tx_data  output  WIDTH  byte for transmitter, held stable from tx_start until the next launch.
REQ-019 tx_busy  input  1  transmitter busy flag.
REQ-020 frames_sent  output  CNT_W  count of launched frames.

Function
REQ-021 Write arbitration is round-robin between req0 and req1, with priority pointer prio (0 favours req0).
REQ-022 With fifo_full=1, neither grant is asserted and fifo_wr_en is 0, whatever the requests.
REQ-023 With fifo_full=0 and exactly one request active, that requester is granted.
REQ-024 With fifo_full=0 and both requests active, the requester selected by prio is granted.
REQ-025 At most one grant is active per cycle; fifo_wr_en = gnt0|gnt1; fifo_w_data is the data of the granted requester, or 0 when no grant.
REQ-026 After any grant, prio points at the other requester on the next cycle; without a grant, prio holds.
REQ-027 Read sequencer is an FSM with states IDLE, POP, LOAD, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-028 IDLE -> POP when fifo_empty=0 and tx_busy=0; fifo_rd_en is 1 for exactly the POP cycle.
REQ-029 POP -> LOAD unconditionally; in LOAD, tx_data is captured from fifo_r_data.
REQ-030 LOAD -> LAUNCH; in LAUNCH, tx_start=1 for one cycle and frames_sent increments, wrapping modulo 2^CNT_W.
REQ-031 LAUNCH -> WAIT_BUSY; WAIT_BUSY -> WAIT_DONE when tx_busy=1; WAIT_DONE -> IDLE when tx_busy=0.
REQ-032 The sequencer never issues a second pop before the previous frame has completed; at most one byte is in flight.
REQ-033 A write and a pop in the same cycle are legal and independent; the arbiter does not gate on sequencer state.
REQ-034 If the FIFO is full at the POP edge, the arbiter may grant from the next cycle, since full deasserts via the FIFO.
REQ-035 Minimum latency from fifo_empty falling (with tx_busy=0, in IDLE) to tx_start is 3 cycles.

Reset
REQ-036 While rst=0: state=IDLE, prio=0, fifo_rd_en=0, tx_start=0, tx_data=0, frames_sent=0; gnt0, gnt1, fifo_wr_en and fifo_w_data are 0.
REQ-037 Reset asserted mid-frame aborts the sequence with no tx_start; after release, the sequencer restarts from IDLE.

Structure
REQ-038 The FSM state encoding and the WIDTH/CNT_W defaults are defined in the shared UART package.
REQ-039 The round-robin arbiter is a separate sub-module, rr_arb2 (req0, req1, block, gnt0, gnt1, with internal prio); the sequencer is inline.

Verification
REQ-040 Reset release, fifo_empty=1 -> all outputs 0, no fifo_rd_en for 20 cycles.
REQ-041 req0=req1=1 held, fifo_full=0, for 4 cycles -> grants alternate gnt0, gnt1, gnt0, gnt1; fifo_w_data alternates data0/data1.
REQ-042 req0=1 with fifo_full=1 for 5 cycles, then full=0 -> gnt0=0 throughout the full period; gnt0=1 in the first non-full cycle.
REQ-043 FIFO holds 0xA5, tx_busy=0 -> fifo_rd_en at cycle 1, tx_start with tx_data=0xA5 at cycle 3, frames_sent=1.
REQ-044 Two bytes 0x11, 0x22 with tx_busy high for 10 cycles after each launch -> second pop only after tx_busy falls; both launched in order.
REQ-045 rst pulsed low during WAIT_BUSY -> no extra tx_start, frames_sent=0; a pending byte is launched after release.

Source files
------------

// File: rtl/uart_tx_fifo_ctrl_pkg.sv
// Purpose : shared types and defaults for the UART transmit FIFO controller slice.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: default data/counter widths and the read-sequencer state encoding.
package uart_tx_fifo_ctrl_pkg;

    // Default byte width on the requester, FIFO and transmitter paths.
    localparam int UART_WIDTH_DEF = 8;
    // Default width of the launched-frame counter.
    localparam int UART_CNT_W_DEF = 16;

    // Read sequencer states. One byte is carried from POP through WAIT_DONE;
    // nothing else is popped until the machine is back in IDLE.
    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_POP       = 3'd1,
        SEQ_LOAD      = 3'd2,
        SEQ_LAUNCH    = 3'd3,
        SEQ_WAIT_BUSY = 3'd4,
        SEQ_WAIT_DONE = 3'd5
    } seq_state_t;

    // True for states that own an in-flight byte.
    function automatic logic seq_in_flight(input seq_state_t s);
        return (s != SEQ_IDLE);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_ctrl_rr_arb2.sv
// Purpose : two-way round-robin arbiter with a global block input.
// Latency : grants are combinational from requests in the same cycle.
// Backpressure: block=1 suppresses both grants; the priority pointer then holds.
//
// Ports: clk/rst_n (async active-low), req0/req1 requests, block inhibit,
//        gnt0/gnt1 one-hot-or-zero grants.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic block,
    output logic gnt0,
    output logic gnt1
);

    // r_prio = 0 favours req0, 1 favours req1 when both are requesting.
    logic r_prio;
    logic w_pick0;
    logic w_pick1;

    always_comb begin
        w_pick0 = req0 & (~req1 | ~r_prio);
        w_pick1 = req1 & (~req0 |  r_prio);
        gnt0    = w_pick0 & ~block;
        gnt1    = w_pick1 & ~block;
    end

    // After a grant the pointer moves to the other requester so a
    // continuously-requesting peer gets the next slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (gnt0) begin
            r_prio <= 1'b1;
        end else if (gnt1) begin
            r_prio <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Purpose : arbitrates two byte writers into a TX FIFO and sequences single
//           bytes from the FIFO into a UART transmitter.
// Latency : write grant same cycle; fifo_empty fall -> tx_start in 3 cycles min.
// Backpressure: fifo_full blocks grants; tx_busy holds the sequencer (one byte in flight).
//
// Ports: clk, rst (async active-low); req0/data0/gnt0, req1/data1/gnt1 writers;
//        fifo_wr_en/fifo_w_data/fifo_full write side; fifo_rd_en/fifo_r_data/
//        fifo_empty read side; tx_start/tx_data/tx_busy transmitter handshake;
//        frames_sent launched-frame counter.
module uart_tx_fifo_ctrl
    import uart_tx_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = UART_WIDTH_DEF,
    parameter int CNT_W = UART_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt1,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_w_data,
    input  logic             fifo_full,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_r_data,
    input  logic             fifo_empty,
    output logic             tx_start,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_busy,
    output logic [CNT_W-1:0] frames_sent
);

    // ------------------------------------------------------------------
    // Write side: round-robin arbitration into the FIFO
    // ------------------------------------------------------------------
    logic w_block;
    logic w_gnt0;
    logic w_gnt1;

    // Grants are combinational, so reset has to be folded into the inhibit
    // to keep them quiet while rst is low.
    assign w_block = fifo_full | ~rst;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst),
        .req0  (req0),
        .req1  (req1),
        .block (w_block),
        .gnt0  (w_gnt0),
        .gnt1  (w_gnt1)
    );

    always_comb begin
        gnt0        = w_gnt0;
        gnt1        = w_gnt1;
        fifo_wr_en  = w_gnt0 | w_gnt1;
        fifo_w_data = '0;
        if (w_gnt0) begin
            fifo_w_data = data0;
        end else if (w_gnt1) begin
            fifo_w_data = data1;
        end
    end

    // ------------------------------------------------------------------
    // Read side: single-byte sequencer
    // ------------------------------------------------------------------
    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic             r_fifo_rd_en;
    logic             r_tx_start;
    logic [WIDTH-1:0] r_tx_data;
    logic [CNT_W-1:0] r_frames_sent;
    logic             w_busy_seq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            SEQ_IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    w_state_nxt = SEQ_POP;
                end
            end
            SEQ_POP:       w_state_nxt = SEQ_LOAD;
            SEQ_LOAD:      w_state_nxt = SEQ_LAUNCH;
            SEQ_LAUNCH:    w_state_nxt = SEQ_WAIT_BUSY;
            // Wait for the transmitter to acknowledge the launch before
            // watching for its completion, otherwise a slow busy rise would
            // look like an already-finished frame.
            SEQ_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = SEQ_WAIT_DONE;
                end
            end
            SEQ_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = SEQ_IDLE;
                end
            end
            default:       w_state_nxt = SEQ_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up exactly
    // with the POP and LAUNCH cycles without combinational decode on the pins.
    // tx_data is sampled at the end of LOAD: fifo_r_data is valid the cycle
    // after the pop edge, and the capture holds until the next LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fifo_rd_en  <= 1'b0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= '0;
            r_frames_sent <= '0;
        end else begin
            r_fifo_rd_en <= (w_state_nxt == SEQ_POP);
            r_tx_start   <= (w_state_nxt == SEQ_LAUNCH);
            if (r_state == SEQ_LOAD) begin
                r_tx_data <= fifo_r_data;
            end
            if (w_state_nxt == SEQ_LAUNCH) begin
                r_frames_sent <= r_frames_sent + CNT_W'(1);
            end
        end
    end

    // Kept for observability from hierarchy; not needed on the pins.
    assign w_busy_seq = seq_in_flight(r_state);

    assign fifo_rd_en  = r_fifo_rd_en;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign frames_sent = r_frames_sent;

endmodule
